// File: rtl/mux_scan_n.sv
// N-channel registered multiplexer with manual select and masked round-robin scan.
// All outputs change only on the rising edge of i_clk.
module mux_scan_n #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned DWELL    = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_mode,
    input  logic [SEL_W-1:0]          i_s,
    input  logic [CHANNELS-1:0]       i_mask,
    input  logic [CHANNELS*WIDTH-1:0] i_w,
    output logic [WIDTH-1:0]          o_f,
    output logic [SEL_W-1:0]          o_ch,
    output logic                      o_valid,
    output logic                      o_step,
    output logic                      o_err
);

    typedef enum logic [1:0] {
        ACT_MANUAL,
        ACT_HOLD,
        ACT_ADVANCE,
        ACT_IDLE
    } act_t;

    act_t             act;
    logic [SEL_W-1:0] ch_q;
    logic [SEL_W-1:0] ch_nxt;
    logic [SEL_W-1:0] scan_nxt;
    logic [SEL_W-1:0] low_idx;
    logic [SEL_W-1:0] above_idx;
    logic             found_low;
    logic             found_above;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] f_nxt;
    logic             valid_nxt;
    logic             step_nxt;
    logic             err_nxt;
    logic             cur_en;
    logic             s_ok;

    assign cur_en = ((i_mask >> ch_q) & CHANNELS'(1)) != '0;
    assign s_ok   = 32'(i_s) < CHANNELS;

    // Next enabled channel above ch_q, else the lowest enabled one (may be ch_q itself).
    always_comb begin
        low_idx     = ch_q;
        above_idx   = ch_q;
        found_low   = 1'b0;
        found_above = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (((i_mask >> k) & CHANNELS'(1)) != '0) begin
                if (!found_low) begin
                    low_idx   = SEL_W'(k);
                    found_low = 1'b1;
                end
                if (!found_above && k > 32'(ch_q)) begin
                    above_idx   = SEL_W'(k);
                    found_above = 1'b1;
                end
            end
        end
        scan_nxt = found_above ? above_idx : low_idx;
    end

    always_comb begin
        act = ACT_MANUAL;
        if (i_mode) begin
            if (i_mask == '0)
                act = ACT_IDLE;
            else if (!cur_en || cnt_q == CNT_W'(DWELL - 1))
                act = ACT_ADVANCE;
            else
                act = ACT_HOLD;
        end
    end

    always_comb begin
        ch_nxt    = ch_q;
        cnt_nxt   = '0;
        valid_nxt = 1'b1;
        step_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (act)
            ACT_MANUAL: begin
                if (s_ok)
                    ch_nxt = i_s;
                else
                    err_nxt = 1'b1;
            end
            ACT_IDLE: valid_nxt = 1'b0;
            ACT_ADVANCE: begin
                ch_nxt   = scan_nxt;
                step_nxt = scan_nxt != ch_q;
            end
            ACT_HOLD: cnt_nxt = cnt_q + CNT_W'(1);
            default: ;
        endcase
        f_nxt = WIDTH'(i_w >> (32'(ch_nxt) * WIDTH));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ch_q    <= '0;
            cnt_q   <= '0;
            o_f     <= '0;
            o_valid <= 1'b0;
            o_step  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            ch_q    <= ch_nxt;
            cnt_q   <= cnt_nxt;
            o_f     <= f_nxt;
            o_valid <= valid_nxt;
            o_step  <= step_nxt;
            o_err   <= err_nxt;
        end
    end

    assign o_ch = ch_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: vector table on a DWELL=3 instance plus
// hand sequences for masking, 3-channel select errors and DWELL=1.
module tb_mux_scan_n;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [1:0]  s;
    logic [3:0]  mask;
    logic [15:0] w;

    logic [3:0] f_a, f_b, f_c, f_d;
    logic [1:0] ch_a, ch_b, ch_c, ch_d;
    logic v_a, st_a, er_a, v_b, st_b, er_b, v_c, st_c, er_c, v_d, st_d, er_d;

    int checks = 0;
    int errors = 0;

    mux_scan_n #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(3), .CNT_W(2)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_s(s), .i_mask(mask), .i_w(w),
        .o_f(f_a), .o_ch(ch_a), .o_valid(v_a), .o_step(st_a), .o_err(er_a));

    mux_scan_n #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(2), .CNT_W(16)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_s(s), .i_mask(mask), .i_w(w),
        .o_f(f_b), .o_ch(ch_b), .o_valid(v_b), .o_step(st_b), .o_err(er_b));

    mux_scan_n #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(2), .CNT_W(16)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_s(s), .i_mask(mask[2:0]), .i_w(w[11:0]),
        .o_f(f_c), .o_ch(ch_c), .o_valid(v_c), .o_step(st_c), .o_err(er_c));

    mux_scan_n #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(1), .CNT_W(1)) dut_d (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_s(s), .i_mask(mask), .i_w(w),
        .o_f(f_d), .o_ch(ch_d), .o_valid(v_d), .o_step(st_d), .o_err(er_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mode;
        logic [1:0]  s;
        logic [3:0]  mask;
        logic [15:0] w;
        logic [3:0]  f;
        logic [1:0]  ch;
        logic        v;
        logic        st;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic m, input logic [1:0] sel, input logic [3:0] mk,
                       input logic [15:0] data, input logic [3:0] ef, input logic [1:0] ech,
                       input logic ev, input logic est, input logic eer);
        vec_t v;
        v.rst = r; v.mode = m; v.s = sel; v.mask = mk; v.w = data;
        v.f = ef; v.ch = ech; v.v = ev; v.st = est; v.er = eer;
        vecs.push_back(v);
    endtask

    // Scan row with full mask and the default data word.
    task automatic sc(input logic [3:0] ef, input logic [1:0] ech, input logic est);
        add(1'b0, 1'b1, 2'd0, 4'hF, 16'hDCBA, ef, ech, 1'b1, est, 1'b0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] f, input logic [1:0] ch,
                       input logic v, input logic st, input logic er,
                       input logic [3:0] ef, input logic [1:0] ech,
                       input logic ev, input logic est, input logic eer);
        checks++;
        if ({f, ch, v, st, er} !== {ef, ech, ev, est, eer}) begin
            errors++;
            $display("FAIL %s: got f=%h ch=%0d valid=%b step=%b err=%b, expected f=%h ch=%0d valid=%b step=%b err=%b",
                     name, f, ch, v, st, er, ef, ech, ev, est, eer);
        end
    endtask

    function automatic logic [3:0] nib(input logic [1:0] ch);
        logic [15:0] word;
        word = 16'hDCBA;
        return word[ch*4 +: 4];
    endfunction

    task automatic step_b(input string name, input logic [3:0] mk, input logic [1:0] ech,
                          input logic ev, input logic est);
        mask = mk;
        tick;
        chk(name, f_b, ch_b, v_b, st_b, er_b, nib(ech), ech, ev, est, 1'b0);
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; s = 2'd0; mask = 4'hF; w = 16'hDCBA;

        // Reset, then manual walk over all four channels.
        add(1, 0, 2'd0, 4'hF, 16'hDCBA, 4'h0, 2'd0, 0, 0, 0);
        add(1, 0, 2'd3, 4'hF, 16'hDCBA, 4'h0, 2'd0, 0, 0, 0);
        add(0, 0, 2'd0, 4'hF, 16'hDCBA, 4'hA, 2'd0, 1, 0, 0);
        add(0, 0, 2'd1, 4'hF, 16'hDCBA, 4'hB, 2'd1, 1, 0, 0);
        add(0, 0, 2'd2, 4'hF, 16'hDCBA, 4'hC, 2'd2, 1, 0, 0);
        add(0, 0, 2'd3, 4'hF, 16'hDCBA, 4'hD, 2'd3, 1, 0, 0);
        add(0, 0, 2'd0, 4'hF, 16'hDCBA, 4'hA, 2'd0, 1, 0, 0);
        // Full wrap, DWELL=3.
        sc(4'hA, 0, 0); sc(4'hA, 0, 0);
        sc(4'hB, 1, 1); sc(4'hB, 1, 0); sc(4'hB, 1, 0);
        sc(4'hC, 2, 1); sc(4'hC, 2, 0); sc(4'hC, 2, 0);
        sc(4'hD, 3, 1); sc(4'hD, 3, 0); sc(4'hD, 3, 0);
        sc(4'hA, 0, 1);
        // Run to ch 2 with cnt 1, then switch to manual mid-dwell.
        sc(4'hA, 0, 0); sc(4'hA, 0, 0);
        sc(4'hB, 1, 1); sc(4'hB, 1, 0); sc(4'hB, 1, 0);
        sc(4'hC, 2, 1); sc(4'hC, 2, 0);
        add(0, 0, 2'd0, 4'hF, 16'hDCBA, 4'hA, 2'd0, 1, 0, 0);
        // Back to scan: ch 0 held a full dwell; run to ch 3 with cnt 2.
        sc(4'hA, 0, 0); sc(4'hA, 0, 0);
        sc(4'hB, 1, 1); sc(4'hB, 1, 0); sc(4'hB, 1, 0);
        sc(4'hC, 2, 1); sc(4'hC, 2, 0); sc(4'hC, 2, 0);
        sc(4'hD, 3, 1); sc(4'hD, 3, 0); sc(4'hD, 3, 0);
        // Reset mid-scan, then ch 0 held again.
        add(1, 1, 2'd0, 4'hF, 16'hDCBA, 4'h0, 2'd0, 0, 0, 0);
        sc(4'hA, 0, 0); sc(4'hA, 0, 0); sc(4'hB, 1, 1);
        // Empty mask: invalid, channel held, data still tracks i_w.
        add(0, 1, 2'd0, 4'h0, 16'h1234, 4'h3, 2'd1, 0, 0, 0);
        add(0, 1, 2'd0, 4'h0, 16'h5678, 4'h7, 2'd1, 0, 0, 0);
        sc(4'hB, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; mode = vecs[i].mode; s = vecs[i].s;
            mask = vecs[i].mask; w = vecs[i].w;
            tick;
            chk($sformatf("vec%0d", i), f_a, ch_a, v_a, st_a, er_a,
                vecs[i].f, vecs[i].ch, vecs[i].v, vecs[i].st, vecs[i].er);
        end

        // Mask skip on DWELL=2.
        rst = 1'b1; mode = 1'b0; s = 2'd0; mask = 4'hF; w = 16'hDCBA;
        tick;
        rst = 1'b0; mode = 1'b1;
        step_b("skip0", 4'b1010, 2'd1, 1, 1);
        step_b("skip1", 4'b1010, 2'd1, 1, 0);
        step_b("skip2", 4'b1010, 2'd3, 1, 1);
        step_b("skip3", 4'b1010, 2'd3, 1, 0);
        step_b("skip4", 4'b1010, 2'd1, 1, 1);
        step_b("skip5", 4'b1010, 2'd1, 1, 0);
        step_b("skip6", 4'b1010, 2'd3, 1, 1);
        step_b("unmask_cur", 4'b0010, 2'd1, 1, 1);
        step_b("idle", 4'b0000, 2'd1, 0, 0);
        step_b("solo_hold", 4'b0010, 2'd1, 1, 0);
        step_b("solo_adv", 4'b0010, 2'd1, 1, 0);

        // Three channels: out-of-range select, then scan wrap 2 -> 0.
        rst = 1'b1; mode = 1'b0; s = 2'd0; mask = 4'b0111; w = 16'hDCBA;
        tick;
        rst = 1'b0;
        s = 2'd2; tick; chk("c3_s2", f_c, ch_c, v_c, st_c, er_c, 4'hC, 2'd2, 1, 0, 0);
        s = 2'd3; tick; chk("c3_bad0", f_c, ch_c, v_c, st_c, er_c, 4'hC, 2'd2, 1, 0, 1);
        s = 2'd3; tick; chk("c3_bad1", f_c, ch_c, v_c, st_c, er_c, 4'hC, 2'd2, 1, 0, 1);
        s = 2'd0; tick; chk("c3_s0", f_c, ch_c, v_c, st_c, er_c, 4'hA, 2'd0, 1, 0, 0);
        mode = 1'b1;
        tick; chk("c3_scan0", f_c, ch_c, v_c, st_c, er_c, 4'hA, 2'd0, 1, 0, 0);
        tick; chk("c3_scan1", f_c, ch_c, v_c, st_c, er_c, 4'hB, 2'd1, 1, 1, 0);
        tick; chk("c3_scan2", f_c, ch_c, v_c, st_c, er_c, 4'hB, 2'd1, 1, 0, 0);
        tick; chk("c3_scan3", f_c, ch_c, v_c, st_c, er_c, 4'hC, 2'd2, 1, 1, 0);
        tick; chk("c3_scan4", f_c, ch_c, v_c, st_c, er_c, 4'hC, 2'd2, 1, 0, 0);
        tick; chk("c3_wrap", f_c, ch_c, v_c, st_c, er_c, 4'hA, 2'd0, 1, 1, 0);

        // DWELL=1 advances every cycle.
        rst = 1'b1; mode = 1'b0; mask = 4'hF;
        tick;
        rst = 1'b0; mode = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            logic [1:0] ech;
            ech = 2'(i);
            tick;
            chk($sformatf("d1_step%0d", i), f_d, ch_d, v_d, st_d, er_d, nib(ech), ech, 1, 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
